instr_fetch_buffer: RTL and testbench

//  Consumer end of the PC unit: accepts each sequential/branch PC it emits, issues it as a

---
 rtl/instr_fetch_buffer.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch_buffer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_buffer
// Brief    : Issues PC-unit fetch addresses to instruction memory and buffers
//            the in-order responses, tagged with their PC, for decode.
//            Optional macro FETCH_BYPASS_EN: zero-latency rvalid->decode path.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_buffer #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PC_WIDTH-1:0]    pc_i,
  input  logic                   pc_valid_i,
  output logic                   pc_ready_o,
  input  logic                   flush_i,
  output logic                   imem_req_o,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]    instr_pc_o,
  input  logic                   instr_ready_i
);

  localparam int             C_PTR_W = $clog2(DEPTH);
  localparam int             C_CNT_W = C_PTR_W + 1;
  localparam logic [C_CNT_W:0] C_DEPTH = (C_CNT_W + 1)'(DEPTH);

  // Entry storage and PC tags of requests awaiting their response
  logic [INSTR_WIDTH-1:0] fifo_data_q [DEPTH];
  logic [PC_WIDTH-1:0]    fifo_pc_q   [DEPTH];
  logic [PC_WIDTH-1:0]    tag_q       [DEPTH];

  logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_PTR_W-1:0] tag_wr_q, tag_wr_d;
  logic [C_PTR_W-1:0] tag_rd_q, tag_rd_d;
  logic [C_CNT_W-1:0] count_q, count_d;
  logic [C_CNT_W-1:0] outst_q, outst_d;
  logic [C_CNT_W-1:0] disc_q, disc_d;

  logic w_credit;
  logic w_req;
  logic w_issue;
  logic w_rsp;
  logic w_keep;
  logic w_empty;
  logic w_byp;
  logic w_wr;
  logic w_pop;

  // Outstanding includes stale responses, so credit stays correct across a flush
  assign w_credit = ({1'b0, count_q} + {1'b0, outst_q}) < C_DEPTH;
  assign w_req    = pc_valid_i & w_credit & ~flush_i;
  assign w_issue  = w_req & imem_gnt_i;
  assign w_rsp    = imem_rvalid_i & (outst_q != '0);
  assign w_keep   = w_rsp & ~flush_i & (disc_q == '0);
  assign w_empty  = (count_q == '0);

  assign imem_req_o  = w_req;
  assign imem_addr_o = pc_i;
  assign pc_ready_o  = w_issue;

`ifdef FETCH_BYPASS_EN
  assign w_byp = w_empty & w_keep;
  assign w_wr  = w_keep & ~(w_byp & instr_ready_i);
`else
  assign w_byp = 1'b0;
  assign w_wr  = w_keep;
`endif

  assign w_pop = ~w_empty & instr_ready_i & ~flush_i;

  always_comb begin
    instr_valid_o = ~w_empty;
    instr_o       = fifo_data_q[rd_ptr_q];
    instr_pc_o    = fifo_pc_q[rd_ptr_q];
    if (w_byp) begin
      instr_valid_o = 1'b1;
      instr_o       = imem_rdata_i;
      instr_pc_o    = tag_q[tag_rd_q];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    count_d  = count_q;
    outst_d  = outst_q;
    disc_d   = disc_q;
    if (flush_i) begin
      // Tags of in-flight requests are dropped; those responses are counted as stale
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      tag_rd_d = tag_wr_q;
      outst_d  = outst_q - C_CNT_W'(w_rsp);
      disc_d   = outst_q - C_CNT_W'(w_rsp);
    end else begin
      if (w_wr)    wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (w_issue) tag_wr_d = tag_wr_q + 1'b1;
      if (w_keep)  tag_rd_d = tag_rd_q + 1'b1;
      if (w_rsp && (disc_q != '0)) disc_d = disc_q - 1'b1;
      count_d = count_q + C_CNT_W'(w_wr) - C_CNT_W'(w_pop);
      outst_d = outst_q + C_CNT_W'(w_issue) - C_CNT_W'(w_rsp);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      disc_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      disc_q   <= disc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
        tag_q[i]       <= '0;
      end
    end else begin
      if (w_wr) begin
        fifo_data_q[wr_ptr_q] <= imem_rdata_i;
        fifo_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
      end
      if (w_issue) tag_q[tag_wr_q] <= pc_i;
    end
  end

`ifndef SYNTHESIS
  a_rvalid_without_request : assert property (
    @(posedge clk) disable iff (!rst_n) !(imem_rvalid_i && (outst_q == '0)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_buffer
// Brief    : Scoreboard bench for instr_fetch_buffer with an in-order memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        pc_ready_o;
  logic        flush_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b1;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b1;

  instr_fetch_buffer #(.PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_i         (pc_i),
    .pc_valid_i   (pc_valid_i),
    .pc_ready_o   (pc_ready_o),
    .flush_i      (flush_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Bench-side model state
  exp_t        exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] popped_pc[$];
  int          m_out = 0;
  int          m_disc = 0;
  int          g_cnt = 0;
  int          n_pop = 0;
  logic        mem_en = 1'b1;
  logic [31:0] rv_addr = '0;

  // In-order memory: answers the oldest granted request when enabled
  always @(posedge clk) begin
    #2;
    if (rst_n && mem_en && pend_q.size() > 0) begin
      rv_addr       = pend_q.pop_front();
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_data(rv_addr);
    end else begin
      imem_rvalid_i = 1'b0;
    end
  end

  task automatic do_pop();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("pop_unexpected", {32'h0, instr_pc_o}, 64'hFFFF_FFFF_FFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("instr_pc", instr_pc_o, e.pc);
      check("instr", instr_o, e.ins);
    end
    popped_pc.push_back(instr_pc_o);
    n_pop++;
  endtask

  logic exp_req, exp_valid, rv_live, rv_keep, popping;
  exp_t new_e;

  always @(negedge clk) begin
    if (rst_n) begin
      exp_req = pc_valid_i && ((exp_q.size() + m_out) < DEPTH) && !flush_i;
      check("imem_req", imem_req_o, exp_req);
      check("pc_ready", pc_ready_o, exp_req && imem_gnt_i);
      if (exp_req) check("imem_addr", imem_addr_o, pc_i);
      rv_live = imem_rvalid_i && (m_out > 0);
      rv_keep = rv_live && !flush_i && (m_disc == 0);
      exp_valid = (exp_q.size() != 0);
`ifdef FETCH_BYPASS_EN
      if (rv_keep) exp_valid = 1'b1;
`endif
      check("instr_valid", instr_valid_o, exp_valid);
      popping = instr_valid_o && instr_ready_i && !flush_i;
`ifndef FETCH_BYPASS_EN
      if (popping) do_pop();
`endif
      if (rv_live) m_out--;
      if (rv_keep) begin
        new_e.pc  = rv_addr;
        new_e.ins = mem_data(rv_addr);
        exp_q.push_back(new_e);
      end else if (rv_live && !flush_i) begin
        m_disc--;
      end
`ifdef FETCH_BYPASS_EN
      if (popping) do_pop();
`endif
      if (flush_i) begin
        exp_q.delete();
        m_disc = m_out;
      end
      if (exp_req && imem_gnt_i) begin
        m_out++;
        g_cnt++;
        pend_q.push_back(pc_i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_n(input int n, input logic [31:0] base);
    int start = g_cnt;
    int guard = 0;
    pc_valid_i = 1'b1;
    while ((g_cnt - start) < n && guard < 200) begin
      pc_i = base + 32'(4 * (g_cnt - start));
      step();
      guard++;
    end
    pc_valid_i = 1'b0;
    if (guard >= 200) check("issue_timeout", 64'(g_cnt - start), 64'(n));
  endtask

  task automatic drain();
    int g = 0;
    pc_valid_i = 1'b0;
    flush_i = 1'b0;
    instr_ready_i = 1'b1;
    imem_gnt_i = 1'b1;
    mem_en = 1'b1;
    while ((m_out != 0 || exp_q.size() != 0) && g < 200) begin
      step();
      g++;
    end
    if (g >= 200) check("drain_timeout", 64'(m_out + exp_q.size()), 64'd0);
    step();
  endtask

  initial begin
    int n0;
    int start;

    // Reset state
    step();
    check("rst_valid", instr_valid_o, 1'b0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", instr_pc_o, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Simple in-order stream
    n0 = n_pop;
    issue_n(3, 32'h0);
    drain();
    check("stream_pops", 64'(n_pop - n0), 64'd3);
    check("stream_last", popped_pc[popped_pc.size() - 1], 32'h8);

    // Backpressure: credit limits grants to DEPTH
    start = g_cnt;
    instr_ready_i = 1'b0;
    pc_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pc_i = 32'h1000 + 32'(4 * (g_cnt - start));
      step();
    end
    check("bp_grants", 64'(g_cnt - start), 64'd4);
    instr_ready_i = 1'b1;
    step();
    instr_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc_i = 32'h1000 + 32'(4 * (g_cnt - start));
      step();
    end
    check("bp_one_more", 64'(g_cnt - start), 64'd5);
    drain();

    // Flush with three requests in flight
    n0 = n_pop;
    mem_en = 1'b0;
    issue_n(3, 32'h200);
    pc_valid_i = 1'b1;
    pc_i = 32'h10;
    flush_i = 1'b1;
    #1;
    check("flush_noreq", imem_req_o, 1'b0);
    step();
    flush_i = 1'b0;
    mem_en = 1'b1;
    issue_n(1, 32'h100);
    drain();
    check("flush_pops", 64'(n_pop - n0), 64'd1);
    check("flush_kept", popped_pc[popped_pc.size() - 1], 32'h100);

    // Flush coinciding with an rvalid, two outstanding
    n0 = n_pop;
    mem_en = 1'b0;
    issue_n(2, 32'h600);
    flush_i = 1'b1;
    mem_en = 1'b1;
    step();
    flush_i = 1'b0;
    issue_n(1, 32'h300);
    drain();
    check("flushrv_pops", 64'(n_pop - n0), 64'd1);
    check("flushrv_kept", popped_pc[popped_pc.size() - 1], 32'h300);

    // Reset with three buffered entries
    instr_ready_i = 1'b0;
    issue_n(3, 32'h400);
    step();
    step();
    step();
    check("pre_rst_valid", instr_valid_o, 1'b1);
    mem_en = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", instr_valid_o, 1'b0);
    check("midrst_pc", instr_pc_o, 32'h0);
    exp_q.delete();
    pend_q.delete();
    m_out = 0;
    m_disc = 0;
    step();
    step();
    rst_n = 1'b1;
    n0 = n_pop;
    start = g_cnt;
    pc_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pc_i = 32'h500 + 32'(4 * (g_cnt - start));
      step();
    end
    check("rst_credit", 64'(g_cnt - start), 64'd4);
    drain();
    check("rst_pops", 64'(n_pop - n0), 64'd4);
    if (n_pop > n0) check("rst_first", popped_pc[n0], 32'h500);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      pc_valid_i    = ($urandom_range(0, 3) != 0);
      pc_i          = $urandom() & 32'hFFFF_FFFC;
      imem_gnt_i    = ($urandom_range(0, 3) != 0);
      instr_ready_i = ($urandom_range(0, 2) != 0);
      mem_en        = ($urandom_range(0, 2) != 0);
      flush_i       = ($urandom_range(0, 24) == 0);
      step();
    end
    drain();
    check("final_empty", instr_valid_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
